// File: rtl/vector_pkg.sv
// vector_pkg: shared defaults and index-width helper for the vector instruction queue.
package vector_pkg;
    localparam int SLICES_DEF = 4;
    localparam int DW_DEF     = 32;
    localparam int DEPTH_DEF  = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/vector_rr_arb.sv
// vector_rr_arb: one-hot round-robin grant, searching upward from rr_ptr.
module vector_rr_arb
    import vector_pkg::*;
#(
    parameter int N  = SLICES_DEF,
    parameter int PW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] rr_ptr,
    output logic [N-1:0]  grant
);
    // Scan from the farthest offset back to rr_ptr so the closest requester wins.
    always_comb begin
        grant = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[PW'((int'(rr_ptr) + k) % N)]) begin
                grant = '0;
                grant[PW'((int'(rr_ptr) + k) % N)] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/vector_instr_queue.sv
// vector_instr_queue: round-robin merge of per-slice instructions into one FIFO
// feeding the execution pipe; head outputs come straight from registers.
module vector_instr_queue
    import vector_pkg::*;
#(
    parameter int  SLICES = SLICES_DEF,
    parameter int  DW     = DW_DEF,
    parameter int  DEPTH  = DEPTH_DEF,
    localparam int SW     = idx_w(SLICES),
    localparam int AW     = $clog2(DEPTH),
    localparam int LW     = AW + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [SLICES-1:0]    instr_valid,
    output logic [SLICES-1:0]    instr_ready,
    input  logic [SLICES*DW-1:0] instr_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [SW-1:0]        out_slice,
    output logic [LW-1:0]        level
);
    logic [LW-1:0]      level_q, level_d;
    logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [SW-1:0]      rr_q, rr_d, gidx;
    logic [SW+DW-1:0]   mem_q [DEPTH];
    logic [SW+DW-1:0]   mem_d [DEPTH];
    logic [SLICES-1:0]  req;
    logic               push, pop, full;

    assign full  = level_q == LW'(DEPTH);
    // Gating by reset_n keeps ready low for the whole reset window, not just after an edge.
    assign req   = instr_valid & {SLICES{reset_n & ~full & ~flush}};
    assign push  = |instr_ready;
    assign out_valid = level_q != '0;
    assign pop   = out_valid & out_ready;
    assign level = level_q;
    assign {out_slice, out_data} = mem_q[rd_q];

    vector_rr_arb #(.N(SLICES), .PW(SW)) u_arb (
        .req   (req),
        .rr_ptr(rr_q),
        .grant (instr_ready)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < SLICES; i++) if (instr_ready[i]) gidx = SW'(i);
        mem_d = mem_q;
        if (push) mem_d[wr_q] = {gidx, instr_data[gidx*DW +: DW]};
        rr_d    = push ? ((gidx == SW'(SLICES - 1)) ? '0 : gidx + 1'b1) : rr_q;
        wr_d    = flush ? '0 : wr_q + AW'(push);
        rd_d    = flush ? '0 : rd_q + AW'(pop);
        level_d = flush ? '0 : level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            rr_q    <= '0;
        end else begin
            level_q <= level_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            rr_q    <= rr_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: tb/tb_vector_instr_queue.sv
// tb_vector_instr_queue: directed scenarios plus random traffic against a queue-based model.
module tb_vector_instr_queue;
    localparam int S = 4;
    localparam int W = 32;
    localparam int D = 8;

    logic           clk = 1'b0;
    logic           reset_n = 1'b1;
    logic [S-1:0]   instr_valid = '0;
    logic [S-1:0]   instr_ready;
    logic [S*W-1:0] instr_data = '0;
    logic           flush = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_data;
    logic [1:0]     out_slice;
    logic [3:0]     level;

    logic [33:0] mq[$];
    int          rr = 0;
    int          checks = 0;
    int          failures = 0;
    logic [S-1:0] last_ready;
    bit          fixed = 1'b0;
    logic [W-1:0] fixval = '0;

    always #5 clk = ~clk;

    vector_instr_queue #(.SLICES(S), .DW(W), .DEPTH(D)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_data (instr_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_slice  (out_slice),
        .level      (level)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, check before the edge, advance the model after it.
    task automatic step(input logic [S-1:0] v, input logic fl, input logic ordy);
        logic [S-1:0] eg;
        logic [W-1:0] dw [S];
        int g;
        @(negedge clk);
        instr_valid = v;
        flush = fl;
        out_ready = ordy;
        for (int i = 0; i < S; i++) begin
            dw[i] = fixed ? fixval : W'($urandom);
            instr_data[i*W +: W] = dw[i];
        end
        g = -1;
        if (!fl && mq.size() < D)
            for (int k = 0; k < S; k++)
                if (g < 0 && v[(rr + k) % S]) g = (rr + k) % S;
        eg = (g < 0) ? '0 : S'(1 << g);
        #1;
        last_ready = instr_ready;
        chk("instr_ready", instr_ready, eg);
        chk("out_valid", out_valid, mq.size() != 0);
        chk("level", level, 64'(mq.size()));
        if (mq.size() != 0) begin
            chk("out_data", out_data, mq[0][31:0]);
            chk("out_slice", out_slice, mq[0][33:32]);
        end
        @(posedge clk);
        if (fl) mq.delete();
        else begin
            if (ordy && mq.size() != 0) void'(mq.pop_front());
            if (g >= 0) begin
                mq.push_back({2'(g), dw[g]});
                rr = (g + 1) % S;
            end
        end
    endtask

    // Reset lands between clock edges so its asynchronous effect is visible at once.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        instr_valid = '1;
        flush = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ready", instr_ready, 0);
        chk("rst_level", level, 0);
        @(negedge clk);
        reset_n = 1'b1;
        instr_valid = '0;
        mq.delete();
        rr = 0;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) step(S'($urandom_range(1, 15)), 1'b0, 1'b0);
    endtask

    initial begin
        do_reset();

        fixed = 1'b1;
        fixval = 32'hA5;
        step(4'b0100, 1'b0, 1'b0);
        chk("single_grant", last_ready, 4'b0100);
        fixed = 1'b0;
        #1;
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 32'hA5);
        chk("single_slice", out_slice, 2);
        chk("single_level", level, 1);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(4'hF, 1'b0, 1'b1);
            chk("rr_seq", last_ready, 64'(1 << (i % 4)));
        end
        for (int i = 0; i < 2; i++) step(4'h0, 1'b0, 1'b1);

        do_reset();
        fill(8);
        step(4'hF, 1'b0, 1'b0);
        chk("full_blocked", last_ready, 0);
        step(4'hF, 1'b0, 1'b1);
        chk("full_pop_only", last_ready, 0);
        step(4'hF, 1'b0, 1'b1);
        chk("full_resume", |last_ready, 1);

        do_reset();
        fill(3);
        for (int i = 0; i < 20; i++) step(S'($urandom_range(1, 15)), 1'b0, 1'b1);
        #1;
        chk("wrap_level", level, 3);
        for (int i = 0; i < 4; i++) step(4'h0, 1'b0, 1'b1);

        do_reset();
        fill(5);
        step(4'hF, 1'b1, 1'b1);
        #1;
        chk("flush_level", level, 0);
        chk("flush_valid", out_valid, 0);
        step(4'h0, 1'b0, 1'b0);

        fill(6);
        do_reset();
        step(4'h0, 1'b0, 1'b0);
        #1;
        chk("post_rst_level", level, 0);

        do_reset();
        for (int i = 0; i < 400; i++)
            step(S'($urandom), $urandom_range(0, 49) == 0,
                 (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vector_instr_queue.md
VECTOR_INSTR_QUEUE -- requirements
Module: vector_instr_queue

Interface
REQ-001 Parameter SLICES, default 4, number of instruction slice inputs (2..8).
REQ-002 Parameter DW, default 32, instruction word width in bits.
REQ-003 Parameter DEPTH, default 8, queue entries; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 instr_valid  input  SLICES  per-slice instruction present, driven by the slice valid outputs of vector_ctrl.
REQ-007 instr_ready  output  SLICES  per-slice accept, returned to the slice ready inputs of vector_ctrl.
REQ-008 instr_data  input  SLICES*DW  slice i occupies bits [i*DW +: DW].
REQ-009 flush  input  1  synchronous discard of all queued entries.
REQ-010 out_valid  output  1  queue head holds an instruction.
REQ-011 out_ready  input  1  downstream execution pipe accepts the head.
REQ-012 out_data  output  DW  head instruction word.
REQ-013 out_slice  output  clog2(SLICES)  originating slice index of the head.
REQ-014 level  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-015 A push occurs when instr_valid[i] and instr_ready[i] are both high; at most one ready bit is high per cycle.
REQ-016 instr_ready is one-hot or zero: it is the round-robin grant among asserted instr_valid bits, gated by (level < DEPTH) and !flush.
REQ-017 Round-robin priority starts at rr_ptr; after a push from slice g, rr_ptr becomes (g+1) mod SLICES; without a push, rr_ptr holds.
REQ-018 instr_ready depends combinationally on instr_valid, level, flush and rr_ptr only, never on out_ready.
REQ-019 A pushed word and its slice index are written to mem[wr_ptr]; wr_ptr increments modulo DEPTH.
REQ-020 out_valid = (level != 0); out_data/out_slice = mem[rd_ptr]; both come from registers, with no combinational path from inputs.
REQ-021 A pop occurs when out_valid and out_ready are both high; rd_ptr increments modulo DEPTH.
REQ-022 Latency: a word pushed in cycle N into an empty queue appears on out_valid in cycle N+1; there is no same-cycle bypass.
REQ-023 Simultaneous push and pop leaves level unchanged; push only adds 1; pop only subtracts 1.
REQ-024 When full (level == DEPTH), all instr_ready bits are low, even if out_ready pops in that cycle.
REQ-025 When empty, out_ready has no effect and out_data is don't-care.
REQ-026 Pointers wrap from DEPTH-1 to 0 without a bubble.
REQ-027 flush has priority: next cycle level=0 and wr_ptr=rd_ptr=0; pushes and pops in the flush cycle are discarded; rr_ptr is unaffected.
REQ-028 Queue order is strict FIFO across slices.

Reset
REQ-029 While reset_n is low: level=0, wr_ptr=rd_ptr=rr_ptr=0, out_valid=0, instr_ready=0.
REQ-030 Reset asserted mid-operation discards all queued entries immediately; mem contents are not reset.
REQ-031 The first push may occur in the first clock edge after reset_n deasserts.

Structure
REQ-032 Package vector_pkg holds the SLICES/DW/DEPTH defaults and the slice-index width function.
REQ-033 Round-robin arbitration lives in sub-module vector_rr_arb (inputs: req vector, rr_ptr; output: one-hot grant).
REQ-034 Storage is a plain register array; no vendor memory primitives.

Verification
REQ-035 Reset, then slice 2 valid with data 0xA5 -> instr_ready=0b0100; next cycle out_valid=1, out_data=0xA5, out_slice=2, level=1.
REQ-036 All 4 slices valid continuously, out_ready=1, rr_ptr=0 -> grants follow 0,1,2,3,0 on consecutive cycles; output order matches.
REQ-037 out_ready=0, push 8 words -> level=8, instr_ready=0; with out_ready=1 and valid held, pop-only in the full cycle, push resumes the next cycle.
REQ-038 Level 3, push and pop in the same cycle -> level stays 3; after 20 such cycles the pointers have wrapped and data order is intact.
REQ-039 Level 5, flush with a concurrent push and pop -> next cycle level=0, out_valid=0, pushed word absent.
REQ-040 reset_n pulsed low asynchronously between edges at level 6 -> out_valid and instr_ready low immediately; level=0 after release.
